// File: rtl/bcd_display_scheduler_if.sv
// Bus between the two numeric sources, the shared hex-to-BCD converter and
// the display scheduler.
//
// Handshake: a source raises its req with a stable value and holds it until
// the matching ack pulses for one cycle; the value is captured on the grant
// edge, so it may change after that. A req still high in the cycle after its
// ack is a fresh request. conv_bcd must be a combinational function of conv_hex.
interface bcd_display_scheduler_if;
  logic [7:0] score;
  logic       score_req;
  logic       score_ack;
  logic [7:0] time_left;
  logic       time_req;
  logic       time_ack;
  logic [7:0] conv_hex;
  logic [7:0] conv_bcd;

  // Sources plus converter side
  modport master (
    output score, score_req, time_left, time_req, conv_bcd,
    input  score_ack, time_ack, conv_hex
  );

  // Scheduler side
  modport slave (
    input  score, score_req, time_left, time_req, conv_bcd,
    output score_ack, time_ack, conv_hex
  );
endinterface

// File: rtl/bcd_display_scheduler.sv
// Shares one hex-to-BCD converter between the score and time sources,
// latches each result into a display register and scans the four BCD
// digits onto active-low digit enables.
module bcd_display_scheduler #(
  parameter logic [15:0] SCAN_DIV = 16'd50000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  bcd_display_scheduler_if.slave        bus,
  output logic                          busy,
  output logic [3:0]                    an,
  output logic [3:0]                    digit_bcd,
  output logic [1:0]                    dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    CAP  = 2'd2
  } state_t;

  localparam logic [15:0] SCAN_LAST = SCAN_DIV - 16'd1;

  state_t      state_q, state_d;
  logic        sel_q, sel_d;          // 0 = score, 1 = time
  logic        rr_q, rr_d;            // 0 = score has priority on a tie
  logic [7:0]  conv_hex_q, conv_hex_d;
  logic [7:0]  disp_score_q, disp_score_d;
  logic [7:0]  disp_time_q, disp_time_d;
  logic        score_ack_q, score_ack_d;
  logic        time_ack_q, time_ack_d;
  logic [15:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic        tick;

  // Values above two decimal digits saturate at 99
  function automatic logic [7:0] clamp99(input logic [7:0] v);
    return (v > 8'd99) ? 8'd99 : v;
  endfunction

  // Controller and display registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sel_q        <= 1'b0;
      rr_q         <= 1'b0;
      conv_hex_q   <= 8'h00;
      disp_score_q <= 8'h00;
      disp_time_q  <= 8'h00;
      score_ack_q  <= 1'b0;
      time_ack_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      rr_q         <= rr_d;
      conv_hex_q   <= conv_hex_d;
      disp_score_q <= disp_score_d;
      disp_time_q  <= disp_time_d;
      score_ack_q  <= score_ack_d;
      time_ack_q   <= time_ack_d;
    end
  end

  // Arbitration, operand capture, result latch and ack generation
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    rr_d         = rr_q;
    conv_hex_d   = conv_hex_q;
    disp_score_d = disp_score_q;
    disp_time_d  = disp_time_q;
    score_ack_d  = 1'b0;
    time_ack_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.score_req && (!bus.time_req || !rr_q)) begin
          sel_d      = 1'b0;
          conv_hex_d = clamp99(bus.score);
          state_d    = CONV;
        end else if (bus.time_req) begin
          sel_d      = 1'b1;
          conv_hex_d = clamp99(bus.time_left);
          state_d    = CONV;
        end
      end
      CONV: state_d = CAP;
      CAP: begin
        if (sel_q) begin
          disp_time_d = bus.conv_bcd;
          time_ack_d  = 1'b1;
        end else begin
          disp_score_d = bus.conv_bcd;
          score_ack_d  = 1'b1;
        end
        rr_d    = ~rr_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Scan counter and digit index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_q <= 16'd0;
      idx_q      <= 2'd0;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
    end
  end

  // Advance the digit index once per SCAN_DIV cycles
  always_comb begin
    tick       = (scan_cnt_q == SCAN_LAST);
    scan_cnt_d = tick ? 16'd0 : scan_cnt_q + 16'd1;
    idx_d      = tick ? idx_q + 2'd1 : idx_q;
  end

  // Select the BCD digit for the current slot
  always_comb begin
    digit_bcd = 4'h0;
    case (idx_q)
      2'd0: digit_bcd = disp_score_q[3:0];
      2'd1: digit_bcd = disp_score_q[7:4];
      2'd2: digit_bcd = disp_time_q[3:0];
      2'd3: digit_bcd = disp_time_q[7:4];
      default: digit_bcd = 4'h0;
    endcase
  end

  // Digit enable, with a zero tens digit blanked when enabled
  always_comb begin
    an = ~(4'b0001 << idx_q);
    if (BLANK_LZ && idx_q[0] && (digit_bcd == 4'h0)) an = 4'b1111;
  end

  assign busy          = (state_q != IDLE);
  assign dbg_state_o   = state_q;
  assign bus.conv_hex  = conv_hex_q;
  assign bus.score_ack = score_ack_q;
  assign bus.time_ack  = time_ack_q;

endmodule

// File: doc/bcd_display_scheduler.md
# bcd_display_scheduler

Sequences the shared combinational hex-to-BCD converter between the two numeric sources of the Whac-A-Mole game: score and remaining time. A round-robin arbiter and a three-state controller present one clamped binary value at a time to the converter and latch its packed-BCD result into a per-source display register. A scan counter then time-multiplexes the four resulting BCD digits onto the 7-segment digit enables. A separate segment decoder sits downstream of `digit_bcd`.

## Interface
- `SCAN_DIV`, default 16'd50000: clk cycles per digit slot. Must be ≥ 2.
- `BLANK_LZ`, default 1: when 1, a tens digit equal to 0 is blanked.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset. Asynchronous, active-high.
- `score`  in  8  binary score value.
- `score_req`  in  1  request to convert `score`; held until `score_ack`.
- `score_ack`  out  1  one-cycle pulse when the score display register has been updated.
- `time_left`  in  8  binary remaining-time value.
- `time_req`  in  1  request to convert `time_left`; held until `time_ack`.
- `time_ack`  out  1  one-cycle pulse when the time display register has been updated.
- `conv_hex`  out  8  registered operand driven to the shared converter.
- `conv_bcd`  in  8  packed-BCD result from the converter; combinational from `conv_hex`.
- `busy`  out  1  high when the controller is not in IDLE.
- `an`  out  4  active-low one-hot digit enable.
- `digit_bcd`  out  4  BCD value of the digit currently enabled.

## Operation
- **Controller FSM** has three states: IDLE, CONV, CAP.
- **IDLE:**
  - With no request pending, it stays in IDLE.
  - When a request is pending, it grants one source and registers `sel`.
  - It loads `conv_hex` with the clamped value: the value if ≤ 99, otherwise 8'd99.
  - It then moves to CONV.
  - The operand is sampled at the grant edge. Later changes to the input do not affect this conversion.
- **CONV:** one settle cycle for the converter, then move to CAP.
- **CAP:**
  - Latch `conv_bcd` into `disp_score` or `disp_time` according to `sel`.
  - Pulse the matching ack for one cycle.
  - Toggle the round-robin pointer so the other source has priority next.
  - Return to IDLE.
- **Arbitration:**
  - If only one request is high, that source is granted.
  - If both are high, the source indicated by the round-robin pointer is granted. After reset the pointer favours score.
- **Request dropped early:** if a req drops before its ack, the conversion already in flight still completes and acks.
- **Request held high:** a req still high after its ack is treated as a new request. A held request therefore re-converts continuously.
- `busy` = (state != IDLE).
- **Scan counter:**
  - 16-bit `scan_cnt` counts 0 … SCAN_DIV−1.
  - Reaching SCAN_DIV−1 is a tick: `scan_cnt` returns to 0 and the 2-bit digit index advances 0→1→2→3→0.
- **Digit mapping:**
  - Index 0 = `disp_score[3:0]`
  - Index 1 = `disp_score[7:4]`
  - Index 2 = `disp_time[3:0]`
  - Index 3 = `disp_time[7:4]`
- `an` = ~(4'b0001 << index).
- **Blanking:** when BLANK_LZ=1 and the selected digit is a tens digit (index 1 or 3) equal to 0, `an` = 4'b1111. `digit_bcd` still shows 0 in that case.
- `an` and `digit_bcd` are combinational from the index and the display registers.

## Timing
- **Reset values** (asynchronous, immediate):
  - state IDLE, `busy` 0.
  - `conv_hex` 8'h00, `disp_score` 8'h00, `disp_time` 8'h00.
  - `score_ack` 0, `time_ack` 0.
  - Round-robin pointer = score.
  - `scan_cnt` 0, index 0.
  - Hence `an` = 4'b1110 and `digit_bcd` = 0.
- **Conversion latency:** a req sampled high in IDLE at edge k gives:
  - `conv_hex` valid after edge k.
  - Display register updated and ack high after edge k+2, deasserting at edge k+3.
  - Controller back in IDLE after edge k+2, so a new grant can occur at edge k+3.
- **Throughput:** one conversion per 3 cycles. With both reqs held, acks alternate score, time, score, … at 3-cycle spacing.
- **Simultaneous events:**
  - A req arriving while `busy` waits; it is never lost while held.
  - A display register changing during a scan slot is reflected in `digit_bcd` immediately.
- **Reset mid-operation:** a conversion in flight is abandoned. No ack is produced, and the display registers clear.
- **Scan slot:** each index value persists exactly SCAN_DIV cycles. The index wraps from 3 to 0 without a gap.

## Test plan
- **Reset check:** assert `rst` mid-cycle with no clock → immediately `an`=4'b1110, `digit_bcd`=0, `busy`=0, `conv_hex`=8'h00, both acks 0.
- **Single score conversion:** `score`=8'h2A, `score_req` high at edge k → `conv_hex`=8'd42 after k; `score_ack` high for exactly one cycle after k+2; `disp_score`=8'h42; `busy` high for 2 cycles.
- **Simultaneous requests:** both reqs high from reset, `score`=7, `time_left`=30 → `score_ack` first with `disp_score`=8'h07, then `time_ack` 3 cycles later with `disp_time`=8'h30, alternating while held.
- **Clamp:** `time_left`=8'd200 → `conv_hex`=8'd99, `disp_time`=8'h99.
- **Scan and blanking:** SCAN_DIV=4, `disp_score`=8'h42, `disp_time`=8'h05, BLANK_LZ=1 → `an` sequence 1110 (`digit_bcd` 2), 1101 (4), 1011 (5), 1111, each for 4 cycles, then wraps to 1110.
- **Reset mid-conversion:** assert `rst` in CONV → no `score_ack` at k+2, `disp_score`=0, FSM in IDLE; after release, a held req restarts a full 3-cycle conversion.
